// File: rtl/conv_feature_sched_if.sv
// conv_feature_sched_if: pixel-in, buffer write/read and tap handshake bundle for the scheduler
interface conv_feature_sched_if #(
   parameter int ADDR_W = 10,
   parameter int KW     = 2
);
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              tap_valid;
   logic              tap_ready;
   logic [KW-1:0]     tap_kr;
   logic [KW-1:0]     tap_kc;
   logic              tap_last;
   logic              frame_last;
   logic              busy;
   logic              done;
   modport master (
      output start, in_valid, tap_ready,
      input  in_ready, wr_en, wr_addr, rd_en, rd_addr, tap_valid,
             tap_kr, tap_kc, tap_last, frame_last, busy, done
   );
   modport slave (
      input  start, in_valid, tap_ready,
      output in_ready, wr_en, wr_addr, rd_en, rd_addr, tap_valid,
             tap_kr, tap_kc, tap_last, frame_last, busy, done
   );
endinterface

// File: rtl/conv_feature_sched.sv
// conv_feature_sched: loads one feature frame into the buffer, then streams every KxK window tap to the MAC
module conv_feature_sched #(
   parameter int IMG_W  = 27,
   parameter int IMG_H  = 27,
   parameter int K      = 3,
   parameter int ADDR_W = 10
) (
   input logic                 clk,
   input logic                 rst,
   conv_feature_sched_if.slave bus
);
   localparam int KW = (K > 1) ? $clog2(K) : 1;
   localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(IMG_W * IMG_H - 1);
   localparam logic [ADDR_W-1:0] OC_MAX  = ADDR_W'(IMG_W - K);
   localparam logic [ADDR_W-1:0] OR_MAX  = ADDR_W'(IMG_H - K);
   localparam logic [KW-1:0]     K_MAX   = KW'(K - 1);
   typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;
   state_t            state;
   logic [ADDR_W-1:0] orow, ocol;
   logic [KW-1:0]     kr, kc;
   logic              kc_end, kr_end, oc_end, or_end;
   assign kc_end         = kc == K_MAX;
   assign kr_end         = kr == K_MAX;
   assign oc_end         = ocol == OC_MAX;
   assign or_end         = orow == OR_MAX;
   assign bus.wr_en      = bus.in_valid & bus.in_ready;
   assign bus.rd_en      = bus.tap_valid & bus.tap_ready;
   assign bus.rd_addr    = (orow + ADDR_W'(kr)) * ADDR_W'(IMG_W) + ocol + ADDR_W'(kc);
   assign bus.tap_kr     = kr;
   assign bus.tap_kc     = kc;
   assign bus.tap_last   = bus.tap_valid & kr_end & kc_end;
   assign bus.frame_last = bus.tap_last & or_end & oc_end;
   // Frame sequencer: load addresses, window/tap counters and registered handshake outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b0;
         bus.tap_valid <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.wr_addr   <= '0;
         orow          <= '0;
         ocol          <= '0;
         kr            <= '0;
         kc            <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               state        <= LOAD;
               bus.in_ready <= 1'b1;
               bus.busy     <= 1'b1;
               bus.wr_addr  <= '0;
            end
            LOAD: if (bus.in_valid) begin
               if (bus.wr_addr == LAST_WR) begin
                  state         <= CONV;
                  bus.in_ready  <= 1'b0;
                  bus.tap_valid <= 1'b1;
               end else begin
                  bus.wr_addr <= bus.wr_addr + ADDR_W'(1);
               end
            end
            CONV: if (bus.tap_ready) begin
               kc <= kc_end ? '0 : kc + KW'(1);
               if (kc_end) kr <= kr_end ? '0 : kr + KW'(1);
               if (kc_end && kr_end) ocol <= oc_end ? '0 : ocol + ADDR_W'(1);
               if (kc_end && kr_end && oc_end) orow <= or_end ? '0 : orow + ADDR_W'(1);
               if (bus.frame_last) begin
                  state         <= DONE;
                  bus.tap_valid <= 1'b0;
                  bus.done      <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_conv_feature_sched.sv
// tb_conv_feature_sched: scoreboard bench for the load/convolve frame sequencer
module tb_conv_feature_sched;
   localparam int IMG_W = 27, IMG_H = 27, K = 3, ADDR_W = 10;
   localparam int N = IMG_W * IMG_H;
   localparam int TAPS = (IMG_W - K + 1) * (IMG_H - K + 1) * K * K;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int checks = 0, errors = 0;
   int taps = 0, done_cnt = 0, ncyc = 0, load_at = 0, conv_at = 0;
   logic conv_pend = 1'b0, rdy_q = 1'b0, prev_fl = 1'b0;
   logic [ADDR_W-1:0] wq[$];
   logic [15:0]       rq[$];
   conv_feature_sched_if #(.ADDR_W(ADDR_W), .KW(2)) bus ();
   conv_feature_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] outs();
      return {bus.in_ready, bus.wr_en, bus.rd_en, bus.tap_valid, bus.tap_last, bus.frame_last,
              bus.busy, bus.done, bus.wr_addr, bus.rd_addr, bus.tap_kr, bus.tap_kc};
   endfunction
   task automatic build_exp();
      wq.delete();
      rq.delete();
      for (int a = 0; a < N; a++) wq.push_back(ADDR_W'(a));
      for (int orow = 0; orow <= IMG_H - K; orow++)
         for (int ocol = 0; ocol <= IMG_W - K; ocol++)
            for (int kr = 0; kr < K; kr++)
               for (int kc = 0; kc < K; kc++) begin
                  logic tl, fl;
                  tl = (kr == K - 1) && (kc == K - 1);
                  fl = tl && (orow == IMG_H - K) && (ocol == IMG_W - K);
                  rq.push_back({ADDR_W'((orow + kr) * IMG_W + ocol + kc), 2'(kr), 2'(kc), tl, fl});
               end
   endtask
   // Monitor: pop and compare writes and taps, track CONV entry and done
   always @(negedge clk) begin
      ncyc++;
      if (rst) begin
         check("overlap", {31'd0, bus.tap_valid & bus.in_ready}, 32'd0);
         if (bus.in_ready && !rdy_q) load_at = ncyc;
         if (conv_pend) begin
            check("conv_entry", {30'd0, bus.tap_valid, bus.in_ready}, 32'd2);
            conv_at = ncyc;
            conv_pend = 1'b0;
         end
         if (bus.wr_en) begin
            check("wr_addr", {22'd0, bus.wr_addr}, wq.size() ? {22'd0, wq.pop_front()} : 32'hffffffff);
            if (bus.wr_addr == ADDR_W'(N - 1)) conv_pend = 1'b1;
         end
         if (bus.rd_en) begin
            check("tap", {16'd0, bus.rd_addr, bus.tap_kr, bus.tap_kc, bus.tap_last, bus.frame_last},
                  rq.size() ? {16'd0, rq.pop_front()} : 32'hffffffff);
            taps++;
         end
         if (bus.done) begin
            done_cnt++;
            check("done_after_last", {31'd0, prev_fl}, 32'd1);
         end
         prev_fl = bus.rd_en & bus.frame_last;
         rdy_q = bus.in_ready;
      end
   end
   task automatic run_frame(input int vp, input int rp, input int abort_at, input bit poke, input bit timing);
      int cyc = 0;
      int d0 = done_cnt;
      build_exp();
      taps = 0;
      bus.in_valid = 1'b0;
      @(posedge clk) #1 bus.start = 1'b1;
      @(posedge clk) #1 bus.start = 1'b0;
      check("load_entry", {19'd0, bus.busy, bus.in_ready, bus.tap_valid, bus.wr_addr}, {19'd0, 3'b110, 10'd0});
      while (!bus.done && cyc < 30000) begin
         bus.in_valid  = $urandom_range(99) < vp;
         bus.tap_ready = $urandom_range(99) < rp;
         bus.start     = poke && (cyc % 500 == 250);
         if (abort_at > 0 && taps >= abort_at) begin
            #1 rst = 1'b0;
            bus.in_valid = 1'b0;
            bus.tap_ready = 1'b0;
            bus.start = 1'b0;
            #1 check("abort_outputs", outs(), 32'd0);
            repeat (3) @(posedge clk);
            @(negedge clk) rst = 1'b1;
            check("abort_no_done", done_cnt, d0);
            check("abort_idle", {31'd0, bus.busy}, 32'd0);
            return;
         end
         @(posedge clk) #1;
         cyc++;
      end
      check("frame_done", {31'd0, bus.done}, 32'd1);
      bus.start = poke;
      bus.in_valid = 1'b0;
      bus.tap_ready = 1'b0;
      @(posedge clk) #1 bus.start = 1'b0;
      check("start_in_done", {30'd0, bus.busy, bus.in_ready}, 32'd0);
      check("tap_count", taps, TAPS);
      check("queues_empty", wq.size() + rq.size(), 32'd0);
      check("done_count", done_cnt - d0, 32'd1);
      if (timing) check("load_len", conv_at - load_at, N);
      repeat (2) @(posedge clk);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.tap_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset", outs(), 32'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      run_frame(100, 100, 0, 1'b0, 1'b1);
      run_frame(60, 55, 0, 1'b1, 1'b0);
      run_frame(80, 70, 3000, 1'b0, 1'b0);
      run_frame(100, 100, 0, 1'b1, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
